// File: rtl/tnn_popcount_accumulator_pkg.sv
// Shared constants and types for the ternary neuron accumulation stages.
package tnn_pkg;

    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_t;

endpackage

// File: rtl/tnn_popcount_accumulator_if.sv
// Chunk-in / result-out handshake bundle of the popcount accumulator.
interface tnn_popcount_accumulator_if #(
    parameter int CNT_W = 4,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] in_popcnt;
    logic [ACC_W-1:0] thr_lo;
    logic [ACC_W-1:0] thr_hi;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_tern;
    logic [ACC_W-1:0] out_sum;

    modport master (
        output in_valid, in_popcnt, thr_lo, thr_hi, out_ready,
        input  in_ready, out_valid, out_tern, out_sum
    );

    modport slave (
        input  in_valid, in_popcnt, thr_lo, thr_hi, out_ready,
        output in_ready, out_valid, out_tern, out_sum
    );
endinterface

// File: rtl/tnn_popcount_accumulator_threshold.sv
// Two-threshold ternary activation; the upper threshold wins when the two overlap.
module tnn_ternary_threshold
    import tnn_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] sum,
    input  logic [ACC_W-1:0] thr_lo,
    input  logic [ACC_W-1:0] thr_hi,
    output logic [1:0]       tern
);

    // Priority compare: +1 first, then -1, otherwise 0.
    always_comb begin
        tern = TERN_ZERO;
        if (sum >= thr_hi) begin
            tern = TERN_POS;
        end else if (sum < thr_lo) begin
            tern = TERN_NEG;
        end
    end

endmodule

// File: rtl/tnn_popcount_accumulator.sv
// Accumulates NUM_CHUNKS popcounts into a saturating neuron sum and emits
// the ternary activation over a valid/ready output.
//
//  state | meaning
//  IDLE  | waiting for the first chunk of a frame
//  ACCUM | 1..NUM_CHUNKS-1 chunks taken
//  HOLD  | result presented, waiting for out_ready
module tnn_popcount_accumulator
    import tnn_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int NUM_CHUNKS = 8,
    parameter int ACC_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sync_clr,
    tnn_popcount_accumulator_if.slave   bus
);

    localparam int              CC_W    = $clog2(NUM_CHUNKS + 1);
    localparam logic [ACC_W:0]  SAT_MAX = {1'b0, {ACC_W{1'b1}}};

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] thr_lo_q;
    logic [ACC_W-1:0] thr_hi_q;
    logic [CC_W-1:0]  chunk_cnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       out_tern_q;
    logic [ACC_W-1:0] out_sum_q;

    logic             accept;
    logic             last_chunk;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;
    logic [ACC_W-1:0] thr_lo_eff;
    logic [ACC_W-1:0] thr_hi_eff;
    logic [1:0]       tern_next;

    // The first chunk of a frame starts from zero and uses the live thresholds,
    // so a one-chunk frame resolves on the same edge the thresholds are latched.
    assign accept     = bus.in_valid & in_ready_q;
    assign base       = (state == IDLE) ? '0 : acc;
    assign sum_wide   = {1'b0, base} + (ACC_W + 1)'(bus.in_popcnt);
    assign sum_sat    = (sum_wide > SAT_MAX) ? '1 : sum_wide[ACC_W-1:0];
    assign thr_lo_eff = (state == IDLE) ? bus.thr_lo : thr_lo_q;
    assign thr_hi_eff = (state == IDLE) ? bus.thr_hi : thr_hi_q;
    assign last_chunk = (state == IDLE) ? (NUM_CHUNKS == 1)
                                        : (chunk_cnt == CC_W'(NUM_CHUNKS - 1));

    tnn_ternary_threshold #(.ACC_W(ACC_W)) u_thr (
        .sum    (sum_sat),
        .thr_lo (thr_lo_eff),
        .thr_hi (thr_hi_eff),
        .tern   (tern_next)
    );

    // Frame FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            thr_lo_q    <= '0;
            thr_hi_q    <= '0;
            chunk_cnt   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_tern_q  <= TERN_ZERO;
            out_sum_q   <= '0;
        end else if (sync_clr) begin
            state       <= IDLE;
            acc         <= '0;
            chunk_cnt   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc <= sum_sat;
                        if (state == IDLE) begin
                            thr_lo_q  <= bus.thr_lo;
                            thr_hi_q  <= bus.thr_hi;
                            chunk_cnt <= CC_W'(1);
                        end else begin
                            chunk_cnt <= chunk_cnt + CC_W'(1);
                        end
                        if (last_chunk) begin
                            out_sum_q   <= sum_sat;
                            out_tern_q  <= tern_next;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state       <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc         <= '0;
                        chunk_cnt   <= '0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tern  = out_tern_q;
    assign bus.out_sum   = out_sum_q;

endmodule

// File: tb/tb_tnn_popcount_accumulator.sv
// Bench for the popcount accumulator: an 8-bit and a 6-bit instance see the
// same stimulus; expected results are queued when a frame is driven and
// popped when the matching output handshake occurs.
module tb_tnn_popcount_accumulator;
    import tnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_clr = 1'b0;

    always #5 clk = ~clk;

    tnn_popcount_accumulator_if #(.CNT_W(4), .ACC_W(8)) bus8 ();
    tnn_popcount_accumulator_if #(.CNT_W(4), .ACC_W(6)) bus6 ();

    tnn_popcount_accumulator #(.CNT_W(4), .NUM_CHUNKS(8), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .bus(bus8.slave)
    );
    tnn_popcount_accumulator #(.CNT_W(4), .NUM_CHUNKS(8), .ACC_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .bus(bus6.slave)
    );

    assign bus6.in_valid  = bus8.in_valid;
    assign bus6.in_popcnt = bus8.in_popcnt;
    assign bus6.thr_lo    = bus8.thr_lo[5:0];
    assign bus6.thr_hi    = bus8.thr_hi[5:0];
    assign bus6.out_ready = bus8.out_ready;

    typedef struct {
        int         sum;
        logic [1:0] tern;
    } exp_t;

    typedef struct {
        logic [3:0] chunk;
        int         lo;
        int         hi;
        int         exp_sum;
        logic [1:0] exp_tern;
    } vec_t;

    exp_t       q8[$];
    exp_t       q6[$];
    exp_t       e8, e6;
    vec_t       vecs[10];
    logic [3:0] chunks[8];
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void model(input int w, input int lo, input int hi,
                                  output int s, output logic [1:0] t);
        int mx, lo_m, hi_m;
        mx = (1 << w) - 1;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            s += int'(chunks[i]);
            if (s > mx) s = mx;
        end
        lo_m = lo & mx;
        hi_m = hi & mx;
        if (s >= hi_m) t = TERN_POS;
        else if (s < lo_m) t = TERN_NEG;
        else t = TERN_ZERO;
    endfunction

    task automatic push_exp(input int s8, input logic [1:0] t8, input int lo, input int hi);
        int s6;
        logic [1:0] t6;
        model(6, lo, hi, s6, t6);
        q8.push_back('{s8, t8});
        q6.push_back('{s6, t6});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus8.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus8.in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic drive_chunk(input logic [3:0] v);
        wait_ready();
        bus8.in_valid  = 1'b1;
        bus8.in_popcnt = v;
        @(posedge clk); #1;
        bus8.in_valid  = 1'b0;
        bus8.in_popcnt = 4'($urandom_range(15));
    endtask

    task automatic send_frame(input int lo, input int hi, input int lo2, input int hi2,
                              input int gap_max);
        bus8.thr_lo = 8'(lo);
        bus8.thr_hi = 8'(hi);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                bus8.thr_lo = 8'(lo2);
                bus8.thr_hi = 8'(hi2);
            end
            drive_chunk(chunks[i]);
            if (i == 6) chk("valid_before_last", int'(bus8.out_valid), 0);
            if (i == 7) chk("valid_latency", int'(bus8.out_valid), 1);
            if (i < 7) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q6.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q8.size() + q6.size(), 0);
    endtask

    // Scoreboard pop on each 8-bit output handshake.
    always @(negedge clk) begin
        if (rst_n && bus8.out_valid && bus8.out_ready) begin
            if (q8.size() == 0) begin
                chk("unexpected_out8", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("sum8", int'(bus8.out_sum), e8.sum);
                chk("tern8", int'(bus8.out_tern), int'(e8.tern));
            end
        end
    end

    // Scoreboard pop on each 6-bit output handshake.
    always @(negedge clk) begin
        if (rst_n && bus6.out_valid && bus6.out_ready) begin
            if (q6.size() == 0) begin
                chk("unexpected_out6", 1, 0);
            end else begin
                e6 = q6.pop_front();
                chk("sum6", int'(bus6.out_sum), e6.sum);
                chk("tern6", int'(bus6.out_tern), int'(e6.tern));
            end
        end
    end

    // Main sequence: reset, table frames, random frames, corner cases.
    initial begin
        int s8;
        logic [1:0] t8;
        int lo, hi;

        bus8.in_valid  = 1'b0;
        bus8.in_popcnt = '0;
        bus8.thr_lo    = '0;
        bus8.thr_hi    = '0;
        bus8.out_ready = 1'b1;

        vecs[0] = '{4'd14, 20,  100, 112, TERN_POS};
        vecs[1] = '{4'd0,  10,  50,  0,   TERN_NEG};
        vecs[2] = '{4'd5,  10,  50,  40,  TERN_ZERO};
        vecs[3] = '{4'd15, 0,   63,  120, TERN_POS};
        vecs[4] = '{4'd10, 90,  70,  80,  TERN_POS};
        vecs[5] = '{4'd10, 20,  80,  80,  TERN_POS};
        vecs[6] = '{4'd4,  32,  100, 32,  TERN_ZERO};
        vecs[7] = '{4'd3,  25,  100, 24,  TERN_NEG};
        vecs[8] = '{4'd10, 20,  81,  80,  TERN_ZERO};
        vecs[9] = '{4'd9,  200, 100, 72,  TERN_NEG};

        #12;
        chk("rst_in_ready", int'(bus8.in_ready), 0);
        chk("rst_out_valid", int'(bus8.out_valid), 0);
        chk("rst_out_sum", int'(bus8.out_sum), 0);
        chk("rst_out_tern", int'(bus8.out_tern), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", int'(bus8.in_ready), 0);
        @(posedge clk); #1;
        chk("in_ready_after_release", int'(bus8.in_ready), 1);

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 8; i++) chunks[i] = vecs[v].chunk;
            push_exp(vecs[v].exp_sum, vecs[v].exp_tern, vecs[v].lo, vecs[v].hi);
            send_frame(vecs[v].lo, vecs[v].hi, $urandom_range(255), $urandom_range(255), v % 3);
            drain();
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) chunks[i] = 4'($urandom_range(15));
            lo = $urandom_range(130);
            hi = $urandom_range(130);
            model(8, lo, hi, s8, t8);
            push_exp(s8, t8, lo, hi);
            send_frame(lo, hi, $urandom_range(255), $urandom_range(255), 2);
            drain();
        end

        // Backpressure: result held while out_ready is low.
        bus8.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) chunks[i] = 4'd2;
        push_exp(16, TERN_ZERO, 5, 30);
        send_frame(5, 30, 5, 30, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", int'(bus8.out_valid), 1);
            chk("bp_sum", int'(bus8.out_sum), 16);
            chk("bp_tern", int'(bus8.out_tern), int'(TERN_ZERO));
            chk("bp_in_ready", int'(bus8.in_ready), 0);
        end
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(bus8.out_valid), 0);
        chk("bp_release_in_ready", int'(bus8.in_ready), 1);
        drain();

        // Async reset mid-frame drops the partial frame immediately.
        for (int i = 0; i < 3; i++) drive_chunk(4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_sum", int'(bus8.out_sum), 0);
        chk("midrst_out_sum6", int'(bus6.out_sum), 0);
        chk("midrst_out_valid", int'(bus8.out_valid), 0);
        chk("midrst_in_ready", int'(bus8.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) chunks[i] = 4'd1;
        push_exp(8, TERN_ZERO, 4, 9);
        send_frame(4, 9, 4, 9, 1);
        drain();

        // sync_clr on the final chunk discards the frame; no result appears.
        for (int i = 0; i < 7; i++) drive_chunk(4'd9);
        wait_ready();
        bus8.in_valid  = 1'b1;
        bus8.in_popcnt = 4'd9;
        sync_clr       = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        sync_clr      = 1'b0;
        chk("clr_out_valid", int'(bus8.out_valid), 0);
        chk("clr_in_ready", int'(bus8.in_ready), 1);
        repeat (4) begin
            @(posedge clk); #1;
        end

        // Thresholds changed after the first chunk must not affect this frame.
        for (int i = 0; i < 8; i++) chunks[i] = 4'd6;
        push_exp(48, TERN_POS, 10, 40);
        send_frame(10, 40, 0, 200, 1);
        drain();

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("final_queue_empty", q8.size() + q6.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
